// File: rtl/clocker_pkg.sv
// Shared types and constants for the multiphase action clock generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clocker_pkg;

    // Sequencer states: stopped, free-running, or executing a single step.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    // Shortest action period the divider will generate, in clk cycles.
    localparam int MIN_PERIOD = 4;

endpackage : clocker_pkg

// File: rtl/multiphase_clocker.sv
// Divided action clock with a setup pulse LEAD cycles ahead of each rising edge.
// Latency: outputs decode registered state; run/step act on the next clk edge.
// Backpressure: none; step requests queue one deep, and extra requests are dropped.
//
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   run           - level: free-run when 1, stop at the end of the period when 0
//   step          - pulse: request one action period while stopped
//   period_in     - requested period in clk cycles (clamped to MIN_PERIOD)
//   action_clk    - low for cnt 0..H-1, high for H..P-1 (H = P/2)
//   action_pulse  - one clk at cnt = max(H-LEAD, 0)
//   period_end    - one clk on the last cycle of each period
//   busy          - a period is in progress
//   cycle_count   - completed periods, wrapping
module multiphase_clocker
    import clocker_pkg::*;
#(
    parameter int CNT_WIDTH      = 8,
    parameter int DEFAULT_PERIOD = 32,
    parameter int LEAD           = 8,
    parameter int CYC_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 step,
    input  logic [CNT_WIDTH-1:0] period_in,
    output logic                 action_clk,
    output logic                 action_pulse,
    output logic                 period_end,
    output logic                 busy,
    output logic [CYC_WIDTH-1:0] cycle_count
);

    localparam logic [CNT_WIDTH-1:0] MIN_P = CNT_WIDTH'(MIN_PERIOD);

    function automatic logic [CNT_WIDTH-1:0] clamp_period(input logic [CNT_WIDTH-1:0] v);
        return (v < MIN_P) ? MIN_P : v;
    endfunction

    localparam logic [CNT_WIDTH-1:0] RST_P = clamp_period(CNT_WIDTH'(DEFAULT_PERIOD));

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic [CNT_WIDTH-1:0] p, p_n;
    logic                 step_pend, step_pend_n;

    logic [CNT_WIDTH-1:0] half;
    logic [CNT_WIDTH-1:0] pulse_at;
    logic [31:0]          half_w;
    logic                 last;
    logic                 pend_eff;

    // Decode of registered state only; nothing here looks at run/step/period_in.
    assign half   = p >> 1;
    assign half_w = 32'(half);
    // Compare in 32 bits so a LEAD wider than the counter still clamps to 0.
    assign pulse_at = (half_w > 32'(LEAD)) ? CNT_WIDTH'(half_w - 32'(LEAD)) : '0;
    assign last     = (cnt == p - CNT_WIDTH'(1));

    assign busy         = (state != IDLE);
    assign action_clk   = busy && (cnt >= half);
    assign action_pulse = busy && (cnt == pulse_at);
    assign period_end   = busy && last;

    // A step arriving on any STEP cycle, including the last, counts as pending.
    assign pend_eff = step_pend | step;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        p_n         = p;
        step_pend_n = step_pend;
        unique case (state)
            IDLE: begin
                cnt_n       = '0;
                p_n         = clamp_period(period_in);
                step_pend_n = 1'b0;
                // run has priority; a simultaneous step is discarded.
                if (run) begin
                    state_n = RUN;
                end else if (step || step_pend) begin
                    state_n = STEP;
                end
            end
            RUN: begin
                step_pend_n = 1'b0;
                if (last) begin
                    cnt_n = '0;
                    p_n   = clamp_period(period_in);
                    if (!run) begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_WIDTH'(1);
                end
            end
            STEP: begin
                if (last) begin
                    cnt_n       = '0;
                    p_n         = clamp_period(period_in);
                    step_pend_n = 1'b0;
                    if (run) begin
                        state_n = RUN;
                    end else if (pend_eff) begin
                        state_n = STEP;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n       = cnt + CNT_WIDTH'(1);
                    step_pend_n = pend_eff;
                end
            end
            default: begin
                state_n     = IDLE;
                cnt_n       = '0;
                step_pend_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            p         <= RST_P;
            step_pend <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            p         <= p_n;
            step_pend <= step_pend_n;
        end
    end

    // period_end is a pure decode of registered state, so a reset cycle
    // never increments the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (period_end) begin
            cycle_count <= cycle_count + CYC_WIDTH'(1);
        end
    end

endmodule : multiphase_clocker

// File: tb/tb_multiphase_clocker.sv
// Directed bench for multiphase_clocker: table of period shapes plus
// hand-written sequences for period change, run drop, stepping and reset.
module tb_multiphase_clocker;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        step;
    logic [7:0]  period_in;
    logic        action_clk;
    logic        action_pulse;
    logic        period_end;
    logic        busy;
    logic [15:0] cycle_count;

    int tests_run = 0;
    int tests_failed = 0;

    multiphase_clocker #(
        .CNT_WIDTH      (8),
        .DEFAULT_PERIOD (32),
        .LEAD           (8),
        .CYC_WIDTH      (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .step         (step),
        .period_in    (period_in),
        .action_clk   (action_clk),
        .action_pulse (action_pulse),
        .period_end   (period_end),
        .busy         (busy),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int period_in;
        int exp_len;
        int exp_low;
        int exp_high;
        int exp_pulse;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clk and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        run  = 1'b0;
        step = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Called at the sample point of cnt 0 of a period. Returns at the sample
    // point of its period_end cycle (or after a bound expires, with len = -1).
    task automatic measure(input int chg_at, input int chg_val, input int drop_at,
                           output int low, output int high, output int pidx,
                           output int pn, output int rise, output int len);
        low = 0; high = 0; pidx = -1; pn = 0; rise = -1; len = -1;
        for (int i = 0; i < 600; i++) begin
            if (action_clk) begin
                high++;
                if (rise < 0) rise = i;
            end else begin
                low++;
            end
            if (action_pulse) begin
                pidx = i;
                pn++;
            end
            if (i == chg_at) period_in = 8'(chg_val);
            if (i == drop_at) run = 1'b0;
            if (period_end) begin
                len = i + 1;
                break;
            end
            tick();
        end
    endtask

    int lo, hi, pi, pn, ri, ln;
    int cc0, nbusy, nend;

    initial begin
        vecs[0] = '{32, 32, 16, 16, 8};
        vecs[1] = '{10, 10, 5, 5, 0};
        vecs[2] = '{2, 4, 2, 2, 0};
        vecs[3] = '{0, 4, 2, 2, 0};
        vecs[4] = '{17, 17, 8, 9, 0};
        vecs[5] = '{40, 40, 20, 20, 12};
        vecs[6] = '{255, 255, 127, 128, 119};

        period_in = 8'd32;
        // Reset state
        do_reset();
        check("rst_busy", int'(busy), 0);
        check("rst_clk", int'(action_clk), 0);
        check("rst_pulse", int'(action_pulse), 0);
        check("rst_end", int'(period_end), 0);
        check("rst_cc", int'(cycle_count), 0);
        tick();
        check("idle_busy", int'(busy), 0);

        // Table of period shapes under free-running mode
        for (int v = 0; v < 7; v++) begin
            do_reset();
            period_in = 8'(vecs[v].period_in);
            tick();
            run = 1'b1;
            tick();
            check($sformatf("v%0d_busy", v), int'(busy), 1);
            cc0 = int'(cycle_count);
            measure(-1, 0, -1, lo, hi, pi, pn, ri, ln);
            check($sformatf("v%0d_len", v), ln, vecs[v].exp_len);
            check($sformatf("v%0d_low", v), lo, vecs[v].exp_low);
            check($sformatf("v%0d_high", v), hi, vecs[v].exp_high);
            check($sformatf("v%0d_rise", v), ri, vecs[v].exp_low);
            check($sformatf("v%0d_pidx", v), pi, vecs[v].exp_pulse);
            check($sformatf("v%0d_pnum", v), pn, 1);
            tick();
            check($sformatf("v%0d_cc", v), int'(cycle_count), cc0 + 1);
        end

        // Period change mid-period takes effect only at the next period
        do_reset();
        period_in = 8'd32;
        tick();
        run = 1'b1;
        tick();
        measure(3, 10, -1, lo, hi, pi, pn, ri, ln);
        check("chg_len0", ln, 32);
        check("chg_pidx0", pi, 8);
        tick();
        measure(-1, 0, -1, lo, hi, pi, pn, ri, ln);
        check("chg_len1", ln, 10);
        check("chg_high1", hi, 5);
        check("chg_pidx1", pi, 0);
        tick();
        check("chg_cc", int'(cycle_count), 2);

        // Dropping run mid-period finishes the period, then stops
        do_reset();
        period_in = 8'd32;
        tick();
        run = 1'b1;
        tick();
        measure(-1, 0, 5, lo, hi, pi, pn, ri, ln);
        check("drop_len", ln, 32);
        tick();
        check("drop_busy", int'(busy), 0);
        check("drop_clk", int'(action_clk), 0);
        check("drop_cc", int'(cycle_count), 1);
        nbusy = 0; nend = 0;
        for (int i = 0; i < 6; i++) begin
            nbusy += int'(busy);
            nend += int'(period_end);
            tick();
        end
        check("drop_idle_busy", nbusy, 0);
        check("drop_idle_end", nend, 0);

        // Step, second step queued, third step dropped: exactly two periods
        do_reset();
        period_in = 8'd8;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        nbusy = 0; nend = 0;
        for (int i = 0; i < 40; i++) begin
            nbusy += int'(busy);
            nend += int'(period_end);
            step = (i == 2 || i == 4);
            tick();
        end
        step = 1'b0;
        check("step_busy_cycles", nbusy, 16);
        check("step_periods", nend, 2);
        check("step_cc", int'(cycle_count), 2);
        check("step_final_busy", int'(busy), 0);

        // run and step together in IDLE: run wins, step is discarded
        do_reset();
        period_in = 8'd8;
        tick();
        run = 1'b1;
        step = 1'b1;
        tick();
        run = 1'b0;
        step = 1'b0;
        nbusy = 0; nend = 0;
        for (int i = 0; i < 30; i++) begin
            nbusy += int'(busy);
            nend += int'(period_end);
            tick();
        end
        check("both_busy_cycles", nbusy, 8);
        check("both_periods", nend, 1);

        // Reset at cnt 20 of the second period aborts it
        do_reset();
        period_in = 8'd32;
        tick();
        run = 1'b1;
        tick();
        measure(-1, 0, -1, lo, hi, pi, pn, ri, ln);
        tick();
        for (int i = 0; i < 20; i++) tick();
        check("mid_cc_before", int'(cycle_count), 1);
        check("mid_clk_before", int'(action_clk), 1);
        rst = 1'b1;
        tick();
        check("mid_busy", int'(busy), 0);
        check("mid_clk", int'(action_clk), 0);
        check("mid_pulse", int'(action_pulse), 0);
        check("mid_end", int'(period_end), 0);
        check("mid_cc", int'(cycle_count), 0);
        rst = 1'b0;
        run = 1'b0;
        tick();
        check("mid_after_busy", int'(busy), 0);
        check("mid_after_cc", int'(cycle_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_multiphase_clocker
